// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared depth/threshold helpers and level type for sync_fifo
package sync_fifo_pkg;

    typedef logic [31:0] level_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit thresholds_legal(input int addr_width, input int af, input int ae);
        return (af >= 1) && (af <= fifo_depth(addr_width)) &&
               (ae >= 0) && (ae <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, one write port, one read port (registered or combinational)
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_READ   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register resets to zero but otherwise only moves on an accepted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = (REG_READ != 0) ? rd_q : mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with optional FWFT, level flags, sticky errors and flush
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!thresholds_legal(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $fatal(1, "sync_fifo: AF_THRESH/AE_THRESH outside legal range");
    end

    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign wr_fire = wr_en & ~full_q;
    assign rd_fire = rd_en & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full_q);
        unf_d    = unf_q | (rd_en & empty_q);
        if (wr_fire) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + ONE;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        // Flush wins over any same-cycle traffic; memory is left as-is.
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (level_t'(count_d) >= level_t'(AF_THRESH));
        ae_d    = (level_t'(count_d) <= level_t'(AE_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   ((FWFT != 0) ? 0 : 1)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_fire & ~clr),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (din),
        .rd_en_i   (rd_fire & ~clr),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    // FWFT head is forced to zero while empty so reset presents dout=0 in both modes.
    assign dout         = ((FWFT != 0) && empty_q) ? '0 : ram_rd_data;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
